// File: rtl/vga_gpu_pkg.sv
// rtl/vga_gpu_pkg.sv - shared types and constants for the VGA GPU pixel path
package vga_gpu_pkg;

    localparam int H_RES_DEFAULT = 640;
    localparam int V_RES_DEFAULT = 480;
    localparam int COORD_W       = 10;
    localparam int COLOR_W       = 12;

    // Instruction decoder opcodes
    localparam logic [3:0] OP_NOOP         = 4'h0;
    localparam logic [3:0] OP_SET_MODE     = 4'h1;
    localparam logic [3:0] OP_SET_BG_COLOR = 4'h2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_FILL  = 2'd2
    } wr_state_t;

    typedef struct packed {
        logic               fill;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [COLOR_W-1:0] color;
    } pixel_cmd_t;

    localparam int CMD_W = $bits(pixel_cmd_t);

    function automatic pixel_cmd_t make_cmd(input logic               fill,
                                            input logic [COORD_W-1:0] x,
                                            input logic [COORD_W-1:0] y,
                                            input logic [COLOR_W-1:0] color);
        pixel_cmd_t c;
        c.fill  = fill;
        c.x     = fill ? '0 : x;
        c.y     = fill ? '0 : y;
        c.color = color;
        return c;
    endfunction

endpackage

// File: rtl/pixel_write_engine_if.sv
// rtl/pixel_write_engine_if.sv - pixel command input, framebuffer write port and status
interface pixel_write_engine_if #(
    parameter int ADDR_W = 19
);
    import vga_gpu_pkg::*;

    logic               i_set_pixel;
    logic               i_fill;
    logic [COORD_W-1:0] i_pixel_x;
    logic [COORD_W-1:0] i_pixel_y;
    logic [COLOR_W-1:0] i_color;
    logic               o_mem_we;
    logic [ADDR_W-1:0]  o_mem_addr;
    logic [COLOR_W-1:0] o_mem_data;
    logic               i_mem_ready;
    logic               o_busy;
    logic               o_full;
    logic               o_overflow;
    logic               o_range_err;

    modport master (
        output i_set_pixel, i_fill, i_pixel_x, i_pixel_y, i_color, i_mem_ready,
        input  o_mem_we, o_mem_addr, o_mem_data, o_busy, o_full, o_overflow, o_range_err
    );

    modport slave (
        input  i_set_pixel, i_fill, i_pixel_x, i_pixel_y, i_color, i_mem_ready,
        output o_mem_we, o_mem_addr, o_mem_data, o_busy, o_full, o_overflow, o_range_err
    );

endinterface

// File: rtl/pixel_cmd_fifo.sv
// rtl/pixel_cmd_fifo.sv - synchronous power-of-two FIFO for pixel commands
module pixel_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 33
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    // A full queue refuses a push even when a pop frees a slot on the same edge
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge i_clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/pixel_write_engine.sv
// rtl/pixel_write_engine.sv - queues pixel/fill commands and writes them to the framebuffer
module pixel_write_engine
    import vga_gpu_pkg::*;
#(
    parameter int H_RES      = H_RES_DEFAULT,
    parameter int V_RES      = V_RES_DEFAULT,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 19
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    pixel_write_engine_if.slave  bus
);
    localparam int                LIM_W     = COORD_W + 1;
    localparam logic [LIM_W-1:0]  X_LIM     = LIM_W'(H_RES);
    localparam logic [LIM_W-1:0]  Y_LIM     = LIM_W'(V_RES);
    localparam logic [ADDR_W-1:0] H_RES_A   = ADDR_W'(H_RES);
    localparam logic [ADDR_W-1:0] FILL_LAST = ADDR_W'(H_RES * V_RES - 1);

    wr_state_t          state, state_nxt;
    logic               mem_we, we_nxt;
    logic [ADDR_W-1:0]  mem_addr, addr_nxt;
    logic [COLOR_W-1:0] mem_data, data_nxt;
    logic               overflow_q, range_err_q;

    logic               cmd_pixel, in_range, want_push, fifo_push, fifo_pop;
    logic               fifo_full, fifo_empty;
    pixel_cmd_t         cmd_in, head;
    logic [CMD_W-1:0]   head_bits;
    logic               xfer, load_ok;
    logic [ADDR_W-1:0]  pix_addr;

    // Fill has priority over a simultaneous pixel strobe; range is checked before fullness
    assign cmd_pixel = bus.i_set_pixel && !bus.i_fill;
    assign in_range  = ({1'b0, bus.i_pixel_x} < X_LIM) && ({1'b0, bus.i_pixel_y} < Y_LIM);
    assign want_push = bus.i_fill || (cmd_pixel && in_range);
    assign fifo_push = want_push && !fifo_full;
    assign cmd_in    = make_cmd(bus.i_fill, bus.i_pixel_x, bus.i_pixel_y, bus.i_color);

    pixel_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .push      (fifo_push),
        .pop       (fifo_pop),
        .wr_data   (cmd_in),
        .rd_data   (head_bits),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign head     = pixel_cmd_t'(head_bits);
    assign pix_addr = ADDR_W'(head.y) * H_RES_A + ADDR_W'(head.x);
    assign xfer     = mem_we && bus.i_mem_ready;

    always_comb begin
        state_nxt = state;
        we_nxt    = mem_we;
        addr_nxt  = mem_addr;
        data_nxt  = mem_data;
        fifo_pop  = 1'b0;
        load_ok   = 1'b0;

        case (state)
            ST_IDLE:  load_ok = 1'b1;
            ST_WRITE: load_ok = xfer;
            ST_FILL: begin
                if (xfer && (mem_addr != FILL_LAST)) addr_nxt = mem_addr + ADDR_W'(1);
                load_ok = xfer && (mem_addr == FILL_LAST);
            end
            default:  load_ok = 1'b1;
        endcase

        // Back-to-back reload keeps mem_we high for one pixel per clock
        if (load_ok) begin
            if (!fifo_empty) begin
                fifo_pop = 1'b1;
                we_nxt   = 1'b1;
                data_nxt = head.color;
                if (head.fill) begin
                    state_nxt = ST_FILL;
                    addr_nxt  = '0;
                end else begin
                    state_nxt = ST_WRITE;
                    addr_nxt  = pix_addr;
                end
            end else begin
                we_nxt    = 1'b0;
                state_nxt = ST_IDLE;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state       <= ST_IDLE;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_data    <= '0;
            overflow_q  <= 1'b0;
            range_err_q <= 1'b0;
        end else begin
            state       <= state_nxt;
            mem_we      <= we_nxt;
            mem_addr    <= addr_nxt;
            mem_data    <= data_nxt;
            overflow_q  <= want_push && fifo_full;
            range_err_q <= cmd_pixel && !in_range;
        end
    end

    assign bus.o_mem_we     = mem_we;
    assign bus.o_mem_addr   = mem_addr;
    assign bus.o_mem_data   = mem_data;
    assign bus.o_full       = fifo_full;
    assign bus.o_busy       = !fifo_empty || (state != ST_IDLE);
    assign bus.o_overflow   = overflow_q;
    assign bus.o_range_err  = range_err_q;

endmodule
